avalon_mem_arbiter: RTL

Two-master Avalon-MM arbiter that shares the single memory slave port between the CPU instruction-fetch master (port I) and the data load/store master (port D). It sits between the CPU core and the RAM model/bus, picks one pending request, replays it to the slave, waits out the slave's `waitrequest`, and returns `readdata` and the completion to the winning master. Arbitration is round-robin, so neither fetch nor data can starve the other.

---
 rtl/avalon_arb_pkg.sv | 29 ++
 rtl/rr_picker_2.sv | 23 ++
 rtl/avalon_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-master Avalon-MM arbiter: FSM states, master ids
// and the captured request record.
package avalon_arb_pkg;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic {MST_I = 1'b0, MST_D = 1'b1} master_id_t;

  typedef struct packed {
    logic [AW-1:0]  address;
    logic [BEW-1:0] byteenable;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
  } avalon_req_t;

  // A master strobing read and write together is served as a plain read.
  function automatic avalon_req_t norm_req(input avalon_req_t r);
    avalon_req_t n;
    n       = r;
    n.write = r.write & ~r.read;
    return n;
  endfunction

endpackage

// File: rtl/rr_picker_2.sv
// Combinational two-way round-robin picker: a tie goes to whichever master
// did not win last time.
module rr_picker_2
  import avalon_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_grant_i,
  output logic       valid_o,
  output master_id_t grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = MST_I;
    case (req_i)
      2'b01:   grant_o = MST_I;
      2'b10:   grant_o = MST_D;
      2'b11:   grant_o = master_id_t'(~last_grant_i);
      default: grant_o = MST_I;
    endcase
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM slave between the instruction-fetch (I) and data (D)
// masters; one transfer in flight at a time, round-robin on ties.
module avalon_mem_arbiter
  import avalon_arb_pkg::*;
#(
  parameter bit PRIORITY_RESET = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [AW-1:0]  i_address,
  input  logic [BEW-1:0] i_byteenable,
  input  logic           i_read,
  input  logic           i_write,
  input  logic [DW-1:0]  i_writedata,
  output logic           i_waitrequest,
  output logic [DW-1:0]  i_readdata,
  input  logic [AW-1:0]  d_address,
  input  logic [BEW-1:0] d_byteenable,
  input  logic           d_read,
  input  logic           d_write,
  input  logic [DW-1:0]  d_writedata,
  output logic           d_waitrequest,
  output logic [DW-1:0]  d_readdata,
  output logic [AW-1:0]  s_address,
  output logic [BEW-1:0] s_byteenable,
  output logic           s_read,
  output logic           s_write,
  output logic [DW-1:0]  s_writedata,
  input  logic           s_waitrequest,
  input  logic [DW-1:0]  s_readdata
);

  arb_state_t            state_q, state_d;
  master_id_t            last_q, last_d;
  master_id_t            gnt_q, gnt_d;
  avalon_req_t           cap_q, cap_d;
  logic                  s_read_q, s_read_d;
  logic                  s_write_q, s_write_d;
  logic [1:0][DW-1:0]    rdata_q, rdata_d;

  avalon_req_t [1:0]     mreq;
  logic [1:0]            req_vld;
  logic                  pick_vld;
  master_id_t            pick_gnt;

  always_comb begin
    mreq[MST_I] = '{address: i_address, byteenable: i_byteenable, read: i_read,
                    write: i_write, writedata: i_writedata};
    mreq[MST_D] = '{address: d_address, byteenable: d_byteenable, read: d_read,
                    write: d_write, writedata: d_writedata};
    req_vld     = {d_read | d_write, i_read | i_write};
  end

  rr_picker_2 u_pick (
    .req_i        (req_vld),
    .last_grant_i (last_q),
    .valid_o      (pick_vld),
    .grant_o      (pick_gnt)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cap_d     = cap_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d     = pick_gnt;
          cap_d     = norm_req(mreq[pick_gnt]);
          s_read_d  = cap_d.read;
          s_write_d = cap_d.write;
          state_d   = ISSUE;
        end
      end
      // The slave only raises waitrequest after it has seen the strobe, so
      // its value during the first strobe cycle means nothing.
      ISSUE: begin
        s_read_d  = cap_q.read;
        s_write_d = cap_q.write;
        state_d   = WAIT;
      end
      WAIT: begin
        if (!s_waitrequest) begin
          if (cap_q.read) rdata_d[gnt_q] = s_readdata;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= master_id_t'(!PRIORITY_RESET);
      gnt_q     <= MST_I;
      cap_q     <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cap_q     <= cap_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_address     = cap_q.address;
  assign s_byteenable  = cap_q.byteenable;
  assign s_writedata   = cap_q.writedata;
  assign s_read        = s_read_q;
  assign s_write       = s_write_q;

  assign i_waitrequest = !(state_q == RESP && gnt_q == MST_I);
  assign d_waitrequest = !(state_q == RESP && gnt_q == MST_D);
  assign i_readdata    = rdata_q[MST_I];
  assign d_readdata    = rdata_q[MST_D];

endmodule
